// File: rtl/cfg_arb_pkg.sv
// cfg_arb_pkg: FSM state type and sizing helpers shared by the config register write arbiter
package cfg_arb_pkg;
  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_e;
  function automatic int aw_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int lock_idx_f(input int nregs);
    return nregs - 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above ptr_i with wraparound
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  // Walk offsets from farthest to nearest so the nearest request overwrites the rest
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (((req_i >> ((int'(ptr_i) + i) % N)) & N'(1)) != '0) begin
        gnt_o = N'(1) << ((int'(ptr_i) + i) % N);
        idx_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/cfg_reg_write_arbiter.sv
// cfg_reg_write_arbiter: round-robin shared write port into a config register bank.
// Define CFG_ARB_LOCK_EN to make the top register a lock mask and add the sticky lock_err output.
module cfg_reg_write_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int                     NREQ  = 2,
  parameter int                     NREGS = 4,
  parameter int                     WIDTH = 8,
  parameter logic [NREGS*WIDTH-1:0] INIT  = '0,
  localparam int                    AW    = aw_f(NREGS),
  localparam int                    IW    = aw_f(NREQ)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        req_ack,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [NREGS*WIDTH-1:0] cfg_q,
  output logic                   busy
`ifdef CFG_ARB_LOCK_EN
  ,
  output logic                   lock_err
`endif
);
  localparam int LOCK = lock_idx_f(NREGS);
  state_e            state_q;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d, stg_idx_q, gnt_idx;
  logic [AW-1:0]     stg_addr_q;
  logic [WIDTH-1:0]  stg_data_q;
  logic [NREQ-1:0]   gnt;
  logic              wr_block;
  // The requester being acked this cycle still shows its old valid, so keep it out of the race
  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req_i (req_valid & ~req_ack),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
  assign rr_ptr_d = (int'(stg_idx_q) == NREQ - 1) ? '0 : stg_idx_q + IW'(1);
  assign rd_data  = cfg_q[int'(rd_addr)*WIDTH +: WIDTH];
  assign busy     = state_q == WRITE;
`ifdef CFG_ARB_LOCK_EN
  assign wr_block = (stg_addr_q != AW'(LOCK)) &&
                    ((cfg_q[LOCK*WIDTH +: WIDTH] & (WIDTH'(1) << stg_addr_q)) != '0);
`else
  assign wr_block = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      stg_idx_q  <= '0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
      cfg_q      <= INIT;
      req_ack    <= '0;
`ifdef CFG_ARB_LOCK_EN
      lock_err   <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      req_ack <= '0;
      if (|gnt) begin
        state_q    <= WRITE;
        stg_idx_q  <= gnt_idx;
        stg_addr_q <= req_addr[int'(gnt_idx)*AW +: AW];
        stg_data_q <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
      end
    end else begin
      state_q  <= IDLE;
      rr_ptr_q <= rr_ptr_d;
      req_ack  <= NREQ'(1) << stg_idx_q;
      if (!wr_block)
        cfg_q[int'(stg_addr_q)*WIDTH +: WIDTH] <= stg_data_q;
`ifdef CFG_ARB_LOCK_EN
      if (wr_block)
        lock_err <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_cfg_reg_write_arbiter.sv
// tb_cfg_reg_write_arbiter: directed checks of reset, single write, contention, fairness, reset abort and lock
module tb_cfg_reg_write_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ack;
  logic [1:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic [31:0] cfg_q;
  logic        busy;
`ifdef CFG_ARB_LOCK_EN
  logic        lock_err;
`endif
  int n_chk = 0;
  int n_pass = 0;
  int cyc;
  logic seen1;
  logic [1:0] exp_ack;
  always #5 clk = ~clk;
  cfg_reg_write_arbiter #(.NREQ(2), .NREGS(4), .WIDTH(8), .INIT(32'h44332211)) dut (
    .CLK       (clk),
    .RST       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cfg_q     (cfg_q),
    .busy      (busy)
`ifdef CFG_ARB_LOCK_EN
    ,
    .lock_err  (lock_err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input int k, input int lim, output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!req_ack[k] && c < lim);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cfg", cfg_q, 32'h44332211);
    chk("rst_busy", busy, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_rd", rd_data, 8'h11);
    req_addr[1:0] = 2'd2;
    req_data[7:0] = 8'hA5;
    req_valid = 2'b01;
    tick();
    chk("w1_busy", busy, 1);
    chk("w1_noack", req_ack, 0);
    tick();
    chk("w1_ack", req_ack, 2'b01);
    chk("w1_bank", cfg_q[23:16], 8'hA5);
    chk("w1_idle", busy, 0);
    rd_addr = 2'd2;
    #1;
    chk("w1_rd", rd_data, 8'hA5);
    req_valid = 2'b00;
    tick();
    chk("w1_pulse", req_ack, 0);
    chk("w1_cfg", cfg_q, 32'h44A52211);
    rst = 1'b1;
    req_addr = {2'd1, 2'd1};
    req_data = {8'h22, 8'h11};
    req_valid = 2'b11;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_ack = (i % 2 == 1) ? 2'b10 : 2'b01;
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (req_ack == 2'b00 && cyc < 4);
      chk($sformatf("cont_ack%0d", i), req_ack, exp_ack);
      chk($sformatf("cont_bank%0d", i), cfg_q[15:8], (exp_ack == 2'b01) ? 8'h11 : 8'h22);
    end
    req_valid = 2'b00;
    chk("cont_cfg", cfg_q, 32'h44332211);
    req_addr[3:2] = 2'd3;
    req_data[15:8] = 8'h33;
    req_valid = 2'b10;
    wait_ack(1, 6, cyc);
    chk("fair_ack1", req_ack, 2'b10);
    req_addr[1:0] = 2'd0;
    req_data[7:0] = 8'h55;
    req_valid = 2'b11;
    cyc = 0;
    seen1 = 1'b0;
    do begin
      tick();
      cyc++;
      if (req_ack[1]) seen1 = 1'b1;
    end while (!req_ack[0] && cyc < 4);
    chk("fair_ack0", req_ack, 2'b01);
    chk("fair_norepeat", seen1, 0);
    req_valid = 2'b10;
    wait_ack(1, 4, cyc);
    chk("fair_ack1b", req_ack, 2'b10);
    req_valid = 2'b00;
    chk("fair_cfg", cfg_q, 32'h33332255);
    req_addr[1:0] = 2'd0;
    req_data[7:0] = 8'hFF;
    req_valid = 2'b01;
    tick();
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    chk("abort_ack", req_ack, 0);
    chk("abort_bank", cfg_q[7:0], 8'h11);
    chk("abort_idle", busy, 0);
    tick();
    chk("abort_ack2", req_ack, 0);
    chk("abort_cfg", cfg_q, 32'h44332211);
`ifdef CFG_ARB_LOCK_EN
    chk("lock_rst", lock_err, 0);
    req_addr[1:0] = 2'd3;
    req_data[7:0] = 8'h01;
    req_valid = 2'b01;
    wait_ack(0, 4, cyc);
    req_valid = 2'b00;
    chk("lock_set_ack", req_ack, 2'b01);
    chk("lock_set_bank", cfg_q[31:24], 8'h01);
    chk("lock_set_err", lock_err, 0);
    req_addr[1:0] = 2'd0;
    req_data[7:0] = 8'h77;
    req_valid = 2'b01;
    wait_ack(0, 4, cyc);
    req_valid = 2'b00;
    chk("lock_wr_ack", req_ack, 2'b01);
    chk("lock_wr_bank", cfg_q[7:0], 8'h11);
    chk("lock_err", lock_err, 1);
    repeat (3) tick();
    chk("lock_sticky", lock_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("lock_clear", lock_err, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cfg_reg_write_arbiter.md
Name: cfg_reg_write_arbiter

Overview:
- Owns a bank of NREGS configuration registers, each WIDTH bits wide, and shares write access among NREQ requesters.
- Arbitration is round-robin. Accepted writes are sequenced through a two-state FSM.
- All register contents are driven continuously to the datapath. A combinational readback port is also provided.
- Sits between software/CSR masters and datapath blocks that consume static configuration.

Parameters:
- NREQ, 2, number of write requesters (2..8)
- NREGS, 4, number of configuration registers (power of two, 2..16)
- WIDTH, 8, bits per register
- INIT, {NREGS*WIDTH{1'b0}}, flattened reset value of the whole bank; register i occupies bits [i*WIDTH +: WIDTH]

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- req_valid  in  NREQ  per-requester write request; held until acked
- req_addr  in  NREQ*AW  per-requester register index, AW = clog2(NREGS); requester k at [k*AW +: AW]
- req_data  in  NREQ*WIDTH  per-requester write data
- req_ack  out  NREQ  one-hot, one-cycle pulse: the request was consumed
- rd_addr  in  AW  readback index
- rd_data  out  WIDTH  combinational: bank[rd_addr]
- cfg_q  out  NREGS*WIDTH  flattened register bank contents
- busy  out  1  high while the FSM is in WRITE

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset, sampled only on the rising edge of CLK while RST=1:
  - cfg_q = INIT; req_ack = 0; busy = 0; FSM = IDLE; round-robin pointer rr_ptr = 0; staging registers = 0.
- FSM states: IDLE and WRITE.
- IDLE:
  - If any req_valid is high, select the first valid requester searching upward from rr_ptr, wrapping modulo NREQ.
  - Latch that requester's index, addr and data into staging; go to WRITE.
  - If no req_valid is high, stay in IDLE.
- WRITE, taking exactly one cycle:
  - On the edge leaving WRITE: bank[stg_addr] <= stg_data; req_ack[stg_idx] = 1 for that cycle; rr_ptr <= (stg_idx+1) mod NREQ; go to IDLE.
  - busy = 1 throughout WRITE.
- req_ack is registered, so it is high in the cycle after WRITE. A requester must treat its request as consumed once it samples req_ack. It may deassert req_valid, or present a new request, in that same cycle.
- Latency: req_valid seen in IDLE → cfg_q updated 2 edges later, coincident with the req_ack pulse.
- Throughput: one write per 2 cycles.
- The FSM re-arbitrates in the same cycle req_ack is high. The requester just acked must therefore not win again from the old sample: while req_ack[k]=1, req_valid[k] is masked out of arbitration.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- Simultaneous requests to the same address from different requesters are serialized; the last granted value wins.
- Changes to req_addr/req_data after latching are ignored. Requesters must hold them stable while req_valid=1.
- RST asserted while in WRITE aborts the write: the bank returns to INIT and no ack is issued.
- rd_addr indexes combinationally. During the ack cycle, rd_data already reflects the new value.

Optional Feature:
- Macro: CFG_ARB_LOCK_EN.
- When defined, the register at index NREGS-1 is a lock mask: bit i set means register i is locked. The lock register itself is never locked.
- A write to a locked register is acked normally, but the bank does not change. A sticky output lock_err (1 bit, reset 0) sets high and clears only on RST.
- When undefined: no lock_err port; all registers are freely writable, including NREGS-1.

Decomposition:
- Package cfg_arb_pkg holds: the FSM state enum (IDLE=1'b0, WRITE=1'b1), the AW derivation function, and the lock-register index constant.
- One sub-module, rr_arbiter: NREQ-wide request vector plus rr_ptr in, one-hot grant plus encoded index out. Purely combinational, reusable elsewhere.

Test Plan:
1. Reset: NREGS=4, WIDTH=8, INIT=32'h44332211 → cfg_q=32'h44332211, busy=0, req_ack=0 on the first cycle after RST deasserts.
2. Single write: req0 addr=2, data=8'hA5 → busy high 1 cycle; req_ack=2'b01 and cfg_q[23:16]=8'hA5 two edges after req_valid is seen; rd_addr=2 → rd_data=8'hA5.
3. Contention: both requesters held valid (req0 addr1=8'h11, req1 addr1=8'h22) from reset → acks in order 01, 10, 01, 10; final bank[1] equals the data of the last ack.
4. Fairness: req1 held continuously and req0 pulsed → req0 acked within 4 cycles of assertion; no back-to-back acks to the same requester while the other is valid.
5. Reset mid-write: RST asserted during WRITE for req0 addr0=8'hFF → no req_ack; bank[0] equals the INIT value.
6. With CFG_ARB_LOCK_EN defined: write reg3=8'h01, then write reg0=8'h77 → reg0 unchanged, ack issued, lock_err=1 and stays 1 until RST.
